// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - ALU command sequencer: 8x8 regfile, command FIFO, single-issue with RAW hazard handling
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_sel/rs1/rs2/rd form the queued entry
//   ld_en/ld_addr/ld_data        host register load, accepted only when ld_ready (= !busy)
//   rd_addr/rd_data              host register read, one-cycle registered latency
//   alu_a/alu_b/alu_sel/alu_addr operands, op code and destination tag for the ALU
//   alu_en                       issue strobe (operand outputs are 0 when low)
//   alu_out/alu_out_addr         registered ALU result and tag, written back when an op is in flight
//   busy                         FIFO non-empty or op in flight
//   op_count                     completed writebacks (wrapping)
// Build option: ALU_SCHED_FWD_EN forwards alu_out into the operands instead of stalling.

module alu_sched #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_sel,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic [2:0]  cmd_rd,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    output logic [2:0]  alu_addr,
    output logic        alu_en,
    input  logic [7:0]  alu_out,
    input  logic [2:0]  alu_out_addr,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [11:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [PTR_W:0]    count, count_nxt;
    logic              inflight;
    logic [2:0]        inflight_rd, ird_nxt;
    logic              hazard_nxt;
    logic [7:0]        rf [8];
    logic [11:0]       head, cmd_entry;
    logic [2:0]        head_sel, head_rs1, head_rs2, head_rd;
    logic [7:0]        op_a, op_b;
    logic              push, issue;
`ifndef ALU_SCHED_FWD_EN
    logic [2:0]        nxt_rs1, nxt_rs2;
`endif

    assign cmd_entry = {cmd_sel, cmd_rs1, cmd_rs2, cmd_rd};
    assign head      = fifo_mem[rd_ptr];
    assign head_sel  = head[11:9];
    assign head_rs1  = head[8:6];
    assign head_rs2  = head[5:3];
    assign head_rd   = head[2:0];

    assign busy      = (count != '0) | inflight;
    assign cmd_ready = (count != FULL);
    assign ld_ready  = !busy;
    assign push      = cmd_valid & cmd_ready;
    assign issue     = (state == ISSUE);

`ifdef ALU_SCHED_FWD_EN
    // The in-flight result is on alu_out this cycle; bypass the regfile for it.
    assign op_a = (inflight && head_rs1 == inflight_rd) ? alu_out : rf[head_rs1];
    assign op_b = (inflight && head_rs2 == inflight_rd) ? alu_out : rf[head_rs2];
`else
    assign op_a = rf[head_rs1];
    assign op_b = rf[head_rs2];
`endif

    // The state register holds the classification of the cycle to come, so the
    // next state is derived from the head and in-flight tag as they will be
    // after this edge.
    always_comb begin
        state_nxt  = IDLE;
        hazard_nxt = 1'b0;
        alu_en     = 1'b0;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_sel    = 3'd0;
        alu_addr   = 3'd0;
        count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(issue);
        rd_ptr_nxt = rd_ptr + PTR_W'(issue);
        ird_nxt    = issue ? head_rd : inflight_rd;
`ifndef ALU_SCHED_FWD_EN
        // With a push landing on the next read slot the FIFO was empty after
        // the pop, so the incoming command becomes the head.
        if (push && wr_ptr == rd_ptr_nxt) begin
            nxt_rs1 = cmd_rs1;
            nxt_rs2 = cmd_rs2;
        end else begin
            nxt_rs1 = fifo_mem[rd_ptr_nxt][8:6];
            nxt_rs2 = fifo_mem[rd_ptr_nxt][5:3];
        end
        hazard_nxt = issue & ((nxt_rs1 == ird_nxt) | (nxt_rs2 == ird_nxt));
`endif
        if (count_nxt != '0) begin
            state_nxt = hazard_nxt ? STALL : ISSUE;
        end
        if (state == ISSUE) begin
            alu_en   = 1'b1;
            alu_a    = op_a;
            alu_b    = op_b;
            alu_sel  = head_sel;
            alu_addr = head_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_rd <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            inflight    <= issue;
            inflight_rd <= ird_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_entry;
        end
    end

    // Writeback and host load never collide: a writeback implies busy, which blocks loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 8'h00;
            end
            rd_data  <= 8'h00;
            op_count <= 16'h0000;
        end else begin
            rd_data <= rf[rd_addr];
            if (inflight) begin
                rf[alu_out_addr] <= alu_out;
                op_count         <= op_count + 16'd1;
            end else if (ld_en && ld_ready) begin
                rf[ld_addr] <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched with behavioural ALU and queue-based model
module tb_alu_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_sel = '0, cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_sel, alu_addr;
    logic        alu_en;
    logic [7:0]  alu_out = 8'h00;
    logic [2:0]  alu_out_addr = 3'd0;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sched #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_addr(alu_addr), .alu_en(alu_en),
        .alu_out(alu_out), .alu_out_addr(alu_out_addr),
        .busy(busy), .op_count(op_count)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    // Registered behavioural ALU
    always @(posedge clk) begin
        if (alu_en) begin
            alu_out      <= alu_f(alu_sel, alu_a, alu_b);
            alu_out_addr <= alu_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: queue of pending commands, array regfile, one pending result
    typedef struct packed {
        logic [2:0] sel;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        hd;
    logic [7:0]  m_rf [8];
    logic        m_inf;
    logic [2:0]  m_ird;
    logic [7:0]  m_res;
    logic [15:0] m_cnt;
    logic [7:0]  m_rd;
    logic        m_en, hz, m_busy, push_ok;
    logic [7:0]  e_a, e_b;
    logic [2:0]  e_sel, e_addr;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
            m_inf = 1'b0;
            m_ird = 3'd0;
            m_res = 8'h00;
            m_cnt = 16'h0;
            m_rd  = 8'h00;
        end else begin
            hd = (mq.size() != 0) ? mq[0] : '0;
            hz = 1'b0;
`ifndef ALU_SCHED_FWD_EN
            hz = m_inf && (hd.rs1 == m_ird || hd.rs2 == m_ird);
`endif
            m_en   = (mq.size() != 0) && !hz;
            e_a    = 8'h00;
            e_b    = 8'h00;
            e_sel  = 3'd0;
            e_addr = 3'd0;
            if (m_en) begin
                e_sel  = hd.sel;
                e_addr = hd.rd;
                e_a    = m_rf[hd.rs1];
                e_b    = m_rf[hd.rs2];
`ifdef ALU_SCHED_FWD_EN
                if (m_inf && hd.rs1 == m_ird) e_a = m_res;
                if (m_inf && hd.rs2 == m_ird) e_b = m_res;
`endif
            end
            m_busy = (mq.size() != 0) || m_inf;

            check("alu_en", alu_en, m_en);
            check("alu_a", alu_a, e_a);
            check("alu_b", alu_b, e_b);
            check("alu_sel", alu_sel, e_sel);
            check("alu_addr", alu_addr, e_addr);
            check("cmd_ready", cmd_ready, mq.size() < 4);
            check("busy", busy, m_busy);
            check("ld_ready", ld_ready, !m_busy);
            check("rd_data", rd_data, m_rd);
            check("op_count", op_count, m_cnt);

            // Advance to the state after the coming rising edge
            push_ok = cmd_valid && (mq.size() < 4);
            m_rd = m_rf[rd_addr];
            if (m_inf) begin
                m_rf[m_ird] = m_res;
                m_cnt++;
            end else if (ld_en && !m_busy) begin
                m_rf[ld_addr] = ld_data;
            end
            if (m_en) void'(mq.pop_front());
            if (push_ok) mq.push_back(cmd_t'({cmd_sel, cmd_rs1, cmd_rs2, cmd_rd}));
            m_inf = m_en;
            if (m_en) begin
                m_ird = e_addr;
                m_res = alu_f(e_sel, e_a, e_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 200) begin
            tick();
            g++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_cmd(input logic [2:0] s, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] d);
        cmd_valid = 1'b1; cmd_sel = s; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = d;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        tick();
        check(name, rd_data, exp);
    endtask

    logic en_seq [3];
    logic saw_full;
    logic acc;
    int   guard;

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) read_reg(3'(i), 8'h00, "reset_reg");
        check("reset_op_count", op_count, 0);
        check("reset_busy", busy, 0);

        // Single op: r3 = r1 + r2
        load(3'd1, 8'h10);
        load(3'd2, 8'h20);
        set_cmd(3'd3, 3'd1, 3'd2, 3'd3);
        tick();
        cmd_valid = 1'b0;
        check("issue_en", alu_en, 1);
        check("issue_a", alu_a, 8'h10);
        check("issue_b", alu_b, 8'h20);
        tick();
        check("issue_pulse", alu_en, 0);
        tick();
        check("wb_op_count", op_count, 1);
        read_reg(3'd3, 8'h30, "wb_r3");

        // Dependent pair: r4 = r1 ^ r2, then r5 = r4 + r2
        set_cmd(3'd2, 3'd1, 3'd2, 3'd4);
        tick();
        en_seq[0] = alu_en;
        set_cmd(3'd3, 3'd4, 3'd2, 3'd5);
        tick();
        cmd_valid = 1'b0;
        en_seq[1] = alu_en;
`ifdef ALU_SCHED_FWD_EN
        check("dep_fwd_a", alu_a, 8'h30);
        tick();
        en_seq[2] = alu_en;
        check("dep_en_seq", {en_seq[0], en_seq[1], en_seq[2]}, 3'b110);
`else
        tick();
        en_seq[2] = alu_en;
        check("dep_stall_a", alu_a, 8'h30);
        check("dep_en_seq", {en_seq[0], en_seq[1], en_seq[2]}, 3'b101);
`endif
        wait_idle();
        read_reg(3'd5, 8'h50, "dep_r5");

        // Hazard chain of 8: r6 = r6 + r1, filling the FIFO when stalls apply
        saw_full = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_cmd(3'd3, 3'd6, 3'd1, 3'd6);
            guard = 0;
            do begin
                acc = cmd_ready;
                if (!cmd_ready) saw_full = 1'b1;
                tick();
                guard++;
            end while (!acc && guard < 100);
            check("chain_accept_timeout", acc, 1);
        end
        cmd_valid = 1'b0;
        wait_idle();
`ifdef ALU_SCHED_FWD_EN
        check("chain_full_seen", saw_full, 0);
`else
        check("chain_full_seen", saw_full, 1);
`endif
        read_reg(3'd6, 8'h80, "chain_r6");
        check("chain_op_count", op_count, 11);

        // Load while busy is dropped; load while idle lands
        set_cmd(3'd0, 3'd1, 3'd2, 3'd0);
        tick();
        cmd_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 8'h55;
        check("ld_busy_ready", ld_ready, 0);
        tick();
        ld_en = 1'b0;
        wait_idle();
        read_reg(3'd7, 8'h00, "ld_busy_r7");
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 8'h55;
        check("ld_idle_ready", ld_ready, 1);
        tick();
        ld_en = 1'b0;
        read_reg(3'd7, 8'h55, "ld_idle_r7");

        // Reset with an op in flight producing 0xAA
        load(3'd1, 8'hAA);
        set_cmd(3'd1, 3'd1, 3'd0, 3'd2);
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) read_reg(3'(i), 8'h00, "mid_rst_reg");
        check("mid_rst_op_count", op_count, 0);
        check("mid_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
